// File: rtl/reg_ctrl_pkg.sv
// Purpose: shared types and constants for register-file write-port control.
// Latency: n/a (package: types, constants, one combinational helper).
// Backpressure: n/a.
// Contents: ctrl_state_t, requester indices, default widths, rr_pick().
package reg_ctrl_pkg;

  // Controller phases: clearing the register file, then serving requesters.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  // Requester indices into the request/grant vectors.
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

  // Default data/pointer widths; these must agree with the register file.
  localparam int DEF_W = 8;
  localparam int DEF_D = 3;

  // Two-way round-robin pick. last_grant holds the index of the requester
  // that most recently completed a handshake. On a tie, the other requester
  // wins. The result is one-hot or zero, and never grants an idle requester.
  function automatic logic [1:0] rr_pick(input logic [1:0] req,
                                         input logic       last_grant);
    logic [1:0] g;
    g = 2'b00;
    if (req[REQ_ALU] && (!req[REQ_LOAD] || last_grant == 1'b1)) begin
      g[REQ_ALU] = 1'b1;
    end else if (req[REQ_LOAD]) begin
      g[REQ_LOAD] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Purpose: two-requester round-robin arbiter with a last-grant flop.
// Latency: grant is combinational from req; last_grant updates on the accept edge.
// Backpressure: a requester that is not granted simply keeps req high and waits.
// Ports: CLK, Reset (async, active-high); req[1:0] in; accept[1:0] in
//        (one-hot completed handshake); gnt[1:0] out (one-hot or zero).
module rr_arbiter2
  import reg_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic [1:0] accept,
  output logic [1:0] gnt
);

  logic last_grant;

  assign gnt = rr_pick(req, last_grant);

  // last_grant resets to LOAD, so ALU wins the first tie after reset.
  // It moves only on a completed handshake. A grant that the parent gates
  // off does not move it.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      last_grant <= 1'b1;
    end else if (accept[REQ_LOAD]) begin
      last_grant <= 1'b1;
    end else if (accept[REQ_ALU]) begin
      last_grant <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// Purpose: clears the register file after reset, then arbitrates its single write port.
// Latency: one cycle from an accepted handshake to the Reg_write_* outputs.
// Backpressure: readies are held low while clearing; afterwards one write is accepted per cycle.
// Ports: CLK, Reset (async, active-high); Alu_*/Load_* valid-ready write requests;
//        Reg_write_en/_address/_data registered to the register file; Init_done.
module reg_write_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int D = DEF_D
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Alu_valid,
  input  logic [D-1:0] Alu_address,
  input  logic [W-1:0] Alu_data,
  output logic         Alu_ready,
  input  logic         Load_valid,
  input  logic [D-1:0] Load_address,
  input  logic [W-1:0] Load_data,
  output logic         Load_ready,
  output logic         Reg_write_en,
  output logic [D-1:0] Reg_write_address,
  output logic [W-1:0] Reg_write_data,
  output logic         Init_done
);

  localparam logic [D-1:0] LAST_ADDR  = {D{1'b1}};
  localparam logic [D-1:0] FIRST_ADDR = D'(1);

  ctrl_state_t  state, state_nxt;
  logic [D-1:0] init_cnt, init_cnt_nxt;
  logic         wr_en_nxt;
  logic [D-1:0] wr_addr_nxt;
  logic [W-1:0] wr_data_nxt;

  logic         run;
  logic [1:0]   req;
  logic [1:0]   gnt_raw;
  logic [1:0]   gnt;
  logic [1:0]   accept;
  logic         any_accept;
  logic [D-1:0] sel_addr;
  logic [W-1:0] sel_data;

  assign run = (state == RUN);
  assign req = {Load_valid, Alu_valid};

  rr_arbiter2 u_arb (
    .CLK    (CLK),
    .Reset  (Reset),
    .req    (req),
    .accept (accept),
    .gnt    (gnt_raw)
  );

  // Grants are suppressed while clearing. The arbiter's last_grant therefore
  // stays frozen until the first real handshake.
  assign gnt        = run ? gnt_raw : 2'b00;
  assign Alu_ready  = gnt[REQ_ALU];
  assign Load_ready = gnt[REQ_LOAD];
  assign accept     = gnt & req;
  assign any_accept = |accept;

  assign sel_addr = accept[REQ_LOAD] ? Load_address : Alu_address;
  assign sel_data = accept[REQ_LOAD] ? Load_data    : Alu_data;

  // State is registered, so Init_done rises on the same edge as the last
  // clearing write.
  assign Init_done = run;

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = Reg_write_address;
    wr_data_nxt  = Reg_write_data;
    case (state)
      INIT: begin
        wr_en_nxt    = 1'b1;
        wr_addr_nxt  = init_cnt;
        wr_data_nxt  = '0;
        init_cnt_nxt = init_cnt + D'(1);
        if (init_cnt == LAST_ADDR) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // A write to address 0 still completes its handshake but is dropped.
        // Address and data keep their previous values.
        if (any_accept && sel_addr != '0) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = sel_addr;
          wr_data_nxt = sel_data;
        end
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state             <= INIT;
      init_cnt          <= FIRST_ADDR;
      Reg_write_en      <= 1'b0;
      Reg_write_address <= '0;
      Reg_write_data    <= '0;
    end else begin
      state             <= state_nxt;
      init_cnt          <= init_cnt_nxt;
      Reg_write_en      <= wr_en_nxt;
      Reg_write_address <= wr_addr_nxt;
      Reg_write_data    <= wr_data_nxt;
    end
  end

  // Handshake invariants relied on by both requesters.
  a_one_ready : assert property (@(posedge CLK) disable iff (Reset)
    !(Alu_ready && Load_ready));
  a_alu_ready_needs_valid : assert property (@(posedge CLK) disable iff (Reset)
    Alu_ready |-> Alu_valid);
  a_load_ready_needs_valid : assert property (@(posedge CLK) disable iff (Reset)
    Load_ready |-> Load_valid);

endmodule

// File: tb/tb_reg_write_ctrl.sv
module tb_reg_write_ctrl;
  import reg_ctrl_pkg::*;

  localparam int W = 8;
  localparam int D = 3;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic         Alu_valid = 1'b0;
  logic [D-1:0] Alu_address = '0;
  logic [W-1:0] Alu_data = '0;
  logic         Alu_ready;
  logic         Load_valid = 1'b0;
  logic [D-1:0] Load_address = '0;
  logic [W-1:0] Load_data = '0;
  logic         Load_ready;
  logic         Reg_write_en;
  logic [D-1:0] Reg_write_address;
  logic [W-1:0] Reg_write_data;
  logic         Init_done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [D-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  logic tb_last = 1'b1;   // reference round-robin state: index of last winner

  always #5 CLK = ~CLK;

  reg_write_ctrl #(.W(W), .D(D)) dut (
    .CLK               (CLK),
    .Reset             (Reset),
    .Alu_valid         (Alu_valid),
    .Alu_address       (Alu_address),
    .Alu_data          (Alu_data),
    .Alu_ready         (Alu_ready),
    .Load_valid        (Load_valid),
    .Load_address      (Load_address),
    .Load_data         (Load_data),
    .Load_ready        (Load_ready),
    .Reg_write_en      (Reg_write_en),
    .Reg_write_address (Reg_write_address),
    .Reg_write_data    (Reg_write_data),
    .Init_done         (Init_done)
  );

  // Scoreboard: every enabled write must match the oldest expected write.
  always @(negedge CLK) begin
    wr_t e;
    if (!Reset && Reg_write_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write addr=%0d data=%h (no write expected)",
                 Reg_write_address, Reg_write_data);
      end else begin
        e = exp_q.pop_front();
        if (Reg_write_address !== e.addr || Reg_write_data !== e.data) begin
          errors++;
          $display("FAIL sb_write got addr=%0d data=%h want addr=%0d data=%h",
                   Reg_write_address, Reg_write_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic push_exp(input int a, input logic [W-1:0] d);
    wr_t w;
    w.addr = D'(a);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Alu_valid = 1'b1;
    Load_valid = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if (Reg_write_en !== 1'b0 || Reg_write_address !== 3'd0 || Reg_write_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs en=%b addr=%0d data=%h want 0/0/00",
               Reg_write_en, Reg_write_address, Reg_write_data);
    end
    checks++;
    if (Init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_init_done got %b want 0", Init_done);
    end
    checks++;
    if (Alu_ready !== 1'b0 || Load_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_readies alu=%b load=%b want 0/0", Alu_ready, Load_ready);
    end
    Alu_valid = 1'b0;
    Load_valid = 1'b0;
    exp_q.delete();
    for (int a = 1; a < 8; a++) push_exp(a, 8'h00);
    tb_last = 1'b1;
    Reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      #1;
      checks++;
      if (Init_done !== (k == 7)) begin
        errors++;
        $display("FAIL init_done_edge%0d got %b want %b", k, Init_done, (k == 7));
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL init_write_count missing=%0d want 0", exp_q.size());
    end
  endtask

  // Runs right after the last clearing edge: a request can be accepted at once.
  task automatic test_alu_single();
    Alu_valid = 1'b1;
    Alu_address = 3'd3;
    Alu_data = 8'h5A;
    #1;
    checks++;
    if (Alu_ready !== 1'b1 || Load_ready !== 1'b0) begin
      errors++;
      $display("FAIL alu_single_ready alu=%b load=%b want 1/0", Alu_ready, Load_ready);
    end
    push_exp(3, 8'h5A);
    tb_last = 1'b0;
    @(negedge CLK);
    Alu_valid = 1'b0;
    #1;
    checks++;
    if (Reg_write_en !== 1'b1 || Reg_write_address !== 3'd3 || Reg_write_data !== 8'h5A) begin
      errors++;
      $display("FAIL alu_single_write en=%b addr=%0d data=%h want 1/3/5a",
               Reg_write_en, Reg_write_address, Reg_write_data);
    end
    checks++;
    if (Alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL alu_ready_without_valid got %b want 0", Alu_ready);
    end
  endtask

  task automatic test_load_zero();
    @(negedge CLK);
    Load_valid = 1'b1;
    Load_address = 3'd0;
    Load_data = 8'hFF;
    #1;
    checks++;
    if (Load_ready !== 1'b1 || Alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_zero_ready load=%b alu=%b want 1/0", Load_ready, Alu_ready);
    end
    tb_last = 1'b1;
    @(negedge CLK);
    Load_valid = 1'b0;
    #1;
    checks++;
    if (Reg_write_en !== 1'b0 || Reg_write_address !== 3'd3 || Reg_write_data !== 8'h5A) begin
      errors++;
      $display("FAIL load_zero_dropped en=%b addr=%0d data=%h want 0/3/5a",
               Reg_write_en, Reg_write_address, Reg_write_data);
    end
  endtask

  task automatic test_back_to_back();
    logic want_alu;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      Alu_valid = 1'b1;  Alu_address = 3'd2;  Alu_data = 8'h11;
      Load_valid = 1'b1; Load_address = 3'd4; Load_data = 8'h22;
      #1;
      want_alu = (tb_last == 1'b1);
      checks++;
      if (Alu_ready !== want_alu || Load_ready !== !want_alu) begin
        errors++;
        $display("FAIL contention_grant%0d alu=%b load=%b want %b/%b",
                 i, Alu_ready, Load_ready, want_alu, !want_alu);
      end
      if (want_alu) push_exp(2, 8'h11);
      else          push_exp(4, 8'h22);
      tb_last = !want_alu;
    end
    @(negedge CLK);
    Alu_valid = 1'b0;
    Load_valid = 1'b0;
    #1;
    checks++;
    if (Reg_write_en !== 1'b1 || Reg_write_address !== 3'd4 || Reg_write_data !== 8'h22) begin
      errors++;
      $display("FAIL contention_last_write en=%b addr=%0d data=%h want 1/4/22",
               Reg_write_en, Reg_write_address, Reg_write_data);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (Reg_write_en !== 1'b0 || Reg_write_address !== 3'd4 || Reg_write_data !== 8'h22) begin
      errors++;
      $display("FAIL idle_hold en=%b addr=%0d data=%h want 0/4/22",
               Reg_write_en, Reg_write_address, Reg_write_data);
    end
  endtask

  task automatic test_reset_mid_init();
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    exp_q.delete();
    for (int a = 1; a <= 4; a++) push_exp(a, 8'h00);
    Reset = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    Reset = 1'b1;
    #1;
    checks++;
    if (Reg_write_en !== 1'b0 || Reg_write_address !== 3'd0 || Reg_write_data !== 8'h00
        || Init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_init_reset en=%b addr=%0d data=%h done=%b want 0/0/00/0",
               Reg_write_en, Reg_write_address, Reg_write_data, Init_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_init_prefix missing=%0d want 0", exp_q.size());
    end
    @(negedge CLK);
    for (int a = 1; a < 8; a++) push_exp(a, 8'h00);
    tb_last = 1'b1;
    Reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      #1;
      checks++;
      if (Init_done !== (k == 7)) begin
        errors++;
        $display("FAIL restart_done_edge%0d got %b want %b", k, Init_done, (k == 7));
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_write_count missing=%0d want 0", exp_q.size());
    end
  endtask

  // Both requesters wait through clearing; ALU must win the first tie.
  task automatic test_valid_during_init();
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    exp_q.delete();
    for (int a = 1; a < 8; a++) push_exp(a, 8'h00);
    tb_last = 1'b1;
    Alu_valid = 1'b1;  Alu_address = 3'd6;  Alu_data = 8'hC3;
    Load_valid = 1'b1; Load_address = 3'd5; Load_data = 8'h3C;
    Reset = 1'b0;
    #1;
    checks++;
    if (Alu_ready !== 1'b0 || Load_ready !== 1'b0) begin
      errors++;
      $display("FAIL init_ready_edge0 alu=%b load=%b want 0/0", Alu_ready, Load_ready);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      #1;
      checks++;
      if (Alu_ready !== (k == 7) || Load_ready !== 1'b0) begin
        errors++;
        $display("FAIL init_ready_edge%0d alu=%b load=%b want %b/0",
                 k, Alu_ready, Load_ready, (k == 7));
      end
    end
    push_exp(6, 8'hC3);
    tb_last = 1'b0;
    @(negedge CLK);
    Alu_valid = 1'b0;
    #1;
    checks++;
    if (Load_ready !== 1'b1 || Alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_init_load_ready load=%b alu=%b want 1/0", Load_ready, Alu_ready);
    end
    checks++;
    if (Reg_write_en !== 1'b1 || Reg_write_address !== 3'd6 || Reg_write_data !== 8'hC3) begin
      errors++;
      $display("FAIL post_init_alu_write en=%b addr=%0d data=%h want 1/6/c3",
               Reg_write_en, Reg_write_address, Reg_write_data);
    end
    push_exp(5, 8'h3C);
    tb_last = 1'b1;
    @(negedge CLK);
    Load_valid = 1'b0;
    #1;
    checks++;
    if (Reg_write_en !== 1'b1 || Reg_write_address !== 3'd5 || Reg_write_data !== 8'h3C) begin
      errors++;
      $display("FAIL post_init_load_write en=%b addr=%0d data=%h want 1/5/3c",
               Reg_write_en, Reg_write_address, Reg_write_data);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu_single();
    test_load_zero();
    test_back_to_back();
    test_reset_mid_init();
    test_valid_during_init();
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_scoreboard missing=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
